// File: rtl/multi_channel_synchronizer.sv
// Brings WIDTH asynchronous inputs into the CLK domain through a STAGES-deep
// flop chain, then an optional persistence filter and registered edge pulses.
module multi_channel_synchronizer #(
    parameter int               WIDTH  = 1,
    parameter int               STAGES = 3,
    parameter int               FILTER = 0,
    parameter logic [WIDTH-1:0] INIT   = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] OUT,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             CHANGED
);

    localparam int CW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam logic [CW-1:0] FILTER_MAX = CW'(FILTER);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_lvl;
    logic [CW-1:0]    cnt_q    [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             changed_q;

    // sync_q[0] is the only flop allowed to go metastable; only sync_q[1] reads it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= INIT;
            end
        end else begin
            sync_q[0] <= IN;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_lvl = sync_q[STAGES-1];

    // OUT follows SYNC only after FILTER+1 consecutive mismatching edges.
    always_comb begin
        out_next = out_q;
        cnt_next = '{default: '0};
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_lvl[i] != out_q[i]) begin
                if (cnt_q[i] == FILTER_MAX) begin
                    out_next[i] = sync_lvl[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_q     <= INIT;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '{default: '0};
        end else begin
            out_q     <= out_next;
            rise_q    <= out_next & ~out_q;
            fall_q    <= ~out_next & out_q;
            changed_q <= |(out_next ^ out_q);
            cnt_q     <= cnt_next;
        end
    end

    assign OUT     = out_q;
    assign RISE    = rise_q;
    assign FALL    = fall_q;
    assign CHANGED = changed_q;

endmodule

// File: tb/tb_multi_channel_synchronizer.sv
// Bench for multi_channel_synchronizer: four differently parameterised instances
// driven from one vector table, plus a hand-written latency sequence.
module tb_multi_channel_synchronizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a: W4 S3 F0 INIT0 | dut_b: W1 S2 F4 | dut_c: W1 S2 F10 | dut_d: W4 S3 F0 INIT F
    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
    logic [3:0] in_a = '0, in_d = 4'hF;
    logic       in_b = 1'b0, in_c = 1'b0;
    logic [3:0] out_a, rise_a, fall_a, out_d, rise_d, fall_d;
    logic       out_b, rise_b, fall_b, out_c, rise_c, fall_c;
    logic       chg_a, chg_b, chg_c, chg_d;

    multi_channel_synchronizer #(.WIDTH(4), .STAGES(3), .FILTER(0), .INIT(4'b0000)) dut_a (
        .CLK(clk), .RESET(rst_a), .IN(in_a), .OUT(out_a), .RISE(rise_a), .FALL(fall_a), .CHANGED(chg_a));
    multi_channel_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER(4), .INIT(1'b0)) dut_b (
        .CLK(clk), .RESET(rst_b), .IN(in_b), .OUT(out_b), .RISE(rise_b), .FALL(fall_b), .CHANGED(chg_b));
    multi_channel_synchronizer #(.WIDTH(1), .STAGES(2), .FILTER(10), .INIT(1'b0)) dut_c (
        .CLK(clk), .RESET(rst_c), .IN(in_c), .OUT(out_c), .RISE(rise_c), .FALL(fall_c), .CHANGED(chg_c));
    multi_channel_synchronizer #(.WIDTH(4), .STAGES(3), .FILTER(0), .INIT(4'b1111)) dut_d (
        .CLK(clk), .RESET(rst_d), .IN(in_d), .OUT(out_d), .RISE(rise_d), .FALL(fall_d), .CHANGED(chg_d));

    typedef struct {
        logic [1:0] sel;
        logic       rst;
        logic [3:0] in;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;

    task automatic add(input logic [1:0] sel, input logic rst, input logic [3:0] in,
                       input logic [3:0] out, input logic [3:0] rise, input logic [3:0] fall,
                       input logic chg, input int n = 1);
        vec_t v;
        v.sel = sel; v.rst = rst; v.in = in; v.out = out; v.rise = rise; v.fall = fall; v.chg = chg;
        for (int r = 0; r < n; r++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input vec_t v);
        case (v.sel)
            2'd0: begin rst_a = v.rst; in_a = v.in; end
            2'd1: begin rst_b = v.rst; in_b = v.in[0]; end
            2'd2: begin rst_c = v.rst; in_c = v.in[0]; end
            default: begin rst_d = v.rst; in_d = v.in; end
        endcase
    endtask

    function automatic logic [12:0] observe(input logic [1:0] sel);
        case (sel)
            2'd0:    return {out_a, rise_a, fall_a, chg_a};
            2'd1:    return {3'b0, out_b, 3'b0, rise_b, 3'b0, fall_b, chg_b};
            2'd2:    return {3'b0, out_c, 3'b0, rise_c, 3'b0, fall_c, chg_c};
            default: return {out_d, rise_d, fall_d, chg_d};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] exp_v;
        int          n_edges;

        // dut_a: reset with IN high, release, rise/fall latency, then multi-channel
        add(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 3);
        add(0, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 3);
        add(0, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
        add(0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0, 2);
        add(0, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 3);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1);
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 3);
        add(0, 0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1);
        add(0, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0);
        add(0, 0, 4'b0001, 4'b0100, 4'b0000, 4'b0000, 0, 3);
        add(0, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 1);
        add(0, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);

        // dut_b: 4-cycle pulse is rejected; 5-cycle pulse passes; 5 low cycles to fall
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 4);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 6);
        add(1, 0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 5);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(1, 0, 4'h0, 4'h1, 4'h1, 4'h0, 1);
        add(1, 0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 4);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h1, 1);
        add(1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 0);

        // dut_c: reset while counter is at 7 discards the count and the chain
        add(2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0);
        add(2, 0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 9);
        add(2, 1, 4'h1, 4'h0, 4'h0, 4'h0, 0);
        add(2, 0, 4'h1, 4'h0, 4'h0, 4'h0, 0, 12);
        add(2, 0, 4'h1, 4'h1, 4'h1, 4'h0, 1);
        add(2, 0, 4'h1, 4'h1, 4'h0, 4'h0, 0);

        // dut_d: INIT=1111 and IN=1111 across reset release -> no pulses at all
        add(3, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0);
        add(3, 0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back({vecs[i].out, vecs[i].rise, vecs[i].fall, vecs[i].chg});
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            check($sformatf("vec[%0d] dut%0d", i, vecs[i].sel), observe(vecs[i].sel), exp_v);
        end

        // Hand sequence on dut_a: ch3 rises, measure edges until RISE[3] (bounded)
        @(negedge clk);
        in_a = 4'b1001;
        n_edges = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            n_edges++;
            if (rise_a[3]) break;
        end
        check("ch3_latency_edges", 13'(n_edges), 13'd4);
        check("ch3_rise_cycle", {out_a, rise_a, fall_a, chg_a}, {4'b1001, 4'b1000, 4'b0000, 1'b1});
        @(posedge clk);
        #1;
        check("ch3_rise_single", {out_a, rise_a, fall_a, chg_a}, {4'b1001, 4'b0000, 4'b0000, 1'b0});

        // Random levels on dut_d held steady: OUT never changes from 1111
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            in_d = 4'hF;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
            check($sformatf("dut_d_hold[%0d]", r), {out_d, rise_d, fall_d, chg_d}, {4'hF, 4'h0, 4'h0, 1'b0});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_channel_synchronizer.md
# multi_channel_synchronizer

Parametrised successor to the fixed three-stage flag synchronizer. It brings WIDTH independent asynchronous inputs into the CLK domain through a configurable-depth flip-flop chain. Each channel then passes through an optional stability (glitch) filter and produces registered rise/fall pulses. It is used wherever asynchronous status flags, trigger lines or slow external signals enter a clocked core and need clean levels plus single-cycle edge events.

## Interface
- WIDTH, 1: number of independent channels (1..32).
- STAGES, 3: synchronizer flip-flops per channel (2..8).
- FILTER, 0: extra consecutive cycles a new synchronized level must persist before OUT follows (0..65535; 0 = no filtering).
- INIT, {WIDTH{1'b0}}: reset value of every synchronizer stage and of OUT.
- CLK  input  1  single clock; all logic on posedge CLK.
- RESET  input  1  synchronous, active-high reset.
- IN  input  WIDTH  asynchronous inputs.
- OUT  output  WIDTH  synchronized, filtered levels (registered).
- RISE  output  WIDTH  one-cycle pulse per channel when OUT goes 0->1 (registered).
- FALL  output  WIDTH  one-cycle pulse per channel when OUT goes 1->0 (registered).
- CHANGED  output  1  OR-reduction of RISE|FALL (registered).

## Operation
- Per channel i: chain s0..s(STAGES-1); s0 <= IN[i], sk <= s(k-1); SYNC[i] = s(STAGES-1).
- Filter counter cnt[i], width max(1, clog2(FILTER+1)), unsigned, never wraps.
- Per cycle, per channel (no FSM beyond counter):
  - SYNC == OUT: cnt <= 0, OUT holds.
  - SYNC != OUT and cnt == FILTER: OUT <= SYNC, cnt <= 0.
  - SYNC != OUT and cnt < FILTER: cnt <= cnt+1, OUT holds.
- Result: OUT follows SYNC only after SYNC differs from OUT on FILTER+1 consecutive edges. A mismatch run shorter than that is discarded, and the counter clears on the first edge where SYNC == OUT again.
- RISE[i] <= (next OUT[i] & ~OUT[i]); FALL[i] <= (~next OUT[i] & OUT[i]); both are registered and high in exactly the cycle the new OUT value is first visible.
- CHANGED <= |(RISE_next | FALL_next), aligned with RISE/FALL.
- Channels fully independent; simultaneous events on different channels are reported in the same cycle.
- RESET (sampled at posedge): all s stages <= INIT, OUT <= INIT, cnt <= 0, RISE/FALL/CHANGED <= 0. RESET overrides all other updates. Pending filter counts are discarded and no pulse is generated by reset itself.
- After reset release, if IN differs from INIT, OUT transitions normally with the normal RISE/FALL pulse.

## Timing
- Reset values: OUT = INIT, RISE = 0, FALL = 0, CHANGED = 0.
- Latency: IN stable from before edge k gives OUT updated after edge k+STAGES+FILTER, with RISE/FALL/CHANGED high for that cycle only.
- FILTER=0, STAGES=3: 3 edges, the same as the legacy block plus edge outputs.
- Level held: OUT stays constant, with no repeated pulses.
- IN toggling faster than FILTER+1 cycles (at SYNC): OUT never changes, no pulses.
- Metastability: only s0 may go metastable; no logic other than s1 reads s0.
- Max one OUT transition per channel per FILTER+1 cycles; RISE and FALL never both high on one channel.

## Test plan
- Reset: WIDTH=1, INIT=0, IN=1, RESET high 3 cycles -> OUT=0, RISE=FALL=CHANGED=0 during reset. After release with STAGES=3, FILTER=0: OUT=1 after edge 3, RISE=1 for one cycle.
- Latency: STAGES=3, FILTER=0, IN 0->1 before edge 0 -> OUT=1 after edge 3, RISE=1 and CHANGED=1 cycle 3 only. IN 1->0 -> FALL single pulse, same latency.
- Filter: STAGES=2, FILTER=4, IN high for 4 cycles -> OUT stays 0, no pulses. IN high for 5 cycles -> OUT=1 after edge 6 from rise, one RISE pulse; OUT returns to 0 only if low for 5 cycles.
- Multi-channel: WIDTH=4, ch0 0->1 and ch2 1->0 before same edge -> RISE=4'b0001 and FALL=4'b0100 in the same cycle, CHANGED=1, ch1/ch3 untouched.
- Reset mid-count: FILTER=10, IN high, RESET asserted when cnt=7 -> after release the full 2+11 edges are required again before OUT=1. No pulse from reset.
- INIT=4'b1111, IN=4'b1111 across reset release -> OUT=1111 throughout, zero RISE/FALL/CHANGED pulses.
